led_display_sched: RTL and testbench



---
 rtl/led_display_sched.sv | 130 +++++++++++++
 tb/tb_led_display_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_display_sched.sv
// Display-mode scheduler for the four-digit LED board: an event FSM picks the mux
// select, and a scan engine strobes one active-low anode at a time with its segment byte.
module led_display_sched #(
  parameter int SCAN_DIV = 50000,
  parameter int HOLD_CYC = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_valid,
  input  logic       ms_valid,
  input  logic       alu_done,
  input  logic       mode_btn,
  input  logic [7:0] LED0,
  input  logic [7:0] LED1,
  input  logic [7:0] LED2,
  input  logic [7:0] LED3,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  // State codes double as the mux select, so sel is simply the state register.
  localparam logic [1:0] ST_IDLE = 2'b11;
  localparam logic [1:0] ST_DIN  = 2'b00;
  localparam logic [1:0] ST_MS   = 2'b01;
  localparam logic [1:0] ST_RES  = 2'b10;

  logic [1:0]        state_reg, state_next;
  logic [SCAN_W-1:0] scan_cnt_reg, scan_cnt_next;
  logic [1:0]        idx_reg, idx_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [3:0]        an_reg, an_next;
  logic [7:0]        seg_reg, seg_next;
  logic [7:0]        led_arr [4];
  logic              ms_timeout;
  logic              state_change;

  assign led_arr[0] = LED0;
  assign led_arr[1] = LED1;
  assign led_arr[2] = LED2;
  assign led_arr[3] = LED3;

  assign ms_timeout   = (state_reg == ST_MS) && (hold_reg == HOLD_LAST);
  assign state_change = (state_next != state_reg);

  // Fixed priority: only the highest asserted event acts; timeout loses to any event.
  always_comb begin
    state_next = state_reg;
    if (alu_done) begin
      state_next = ST_RES;
    end else if (ms_valid) begin
      state_next = ST_MS;
    end else if (din_valid) begin
      state_next = ST_DIN;
    end else if (mode_btn) begin
      case (state_reg)
        ST_IDLE: state_next = ST_DIN;
        ST_DIN:  state_next = ST_MS;
        ST_MS:   state_next = ST_RES;
        default: state_next = ST_DIN;
      endcase
    end else if (ms_timeout) begin
      state_next = ST_DIN;
    end
  end

  // ms_valid while already in SHOW_MS restarts the hold window.
  always_comb begin
    hold_next = hold_reg;
    if ((state_next == ST_MS) && ((state_reg != ST_MS) || ms_valid)) begin
      hold_next = '0;
    end else if ((state_next == ST_MS) && (state_reg == ST_MS)) begin
      hold_next = hold_reg + HOLD_W'(1);
    end
  end

  // A real mode change restarts the scan at digit 0; a re-entry event leaves it running.
  always_comb begin
    scan_cnt_next = scan_cnt_reg;
    idx_next      = idx_reg;
    if (state_change) begin
      scan_cnt_next = '0;
      idx_next      = 2'd0;
    end else if (state_reg != ST_IDLE) begin
      if (scan_cnt_reg == SCAN_LAST) begin
        scan_cnt_next = '0;
        idx_next      = idx_reg + 2'd1;
      end else begin
        scan_cnt_next = scan_cnt_reg + SCAN_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_anode
      assign an_next[gi] = !((state_next != ST_IDLE) && (idx_next == 2'(gi)));
    end
  endgenerate

  assign seg_next = led_arr[idx_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      scan_cnt_reg <= '0;
      idx_reg      <= 2'd0;
      hold_reg     <= '0;
      an_reg       <= 4'b1111;
      seg_reg      <= 8'h00;
    end else begin
      state_reg    <= state_next;
      scan_cnt_reg <= scan_cnt_next;
      idx_reg      <= idx_next;
      hold_reg     <= hold_next;
      an_reg       <= an_next;
      seg_reg      <= seg_next;
    end
  end

  assign sel = state_reg;
  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: tb/tb_led_display_sched.sv
// Bench for led_display_sched: a mode/age model checked every cycle, plus
// directed literal checks along the scenario timeline.
module tb_led_display_sched;

  localparam int SCAN_DIV = 4;
  localparam int HOLD_CYC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid, ms_valid, alu_done, mode_btn;
  logic [7:0] LED0, LED1, LED2, LED3;
  logic [1:0] sel;
  logic [3:0] an;
  logic [7:0] seg;

  int tests = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model: mode 0=IDLE 1=DIN 2=MS 3=RES; age = cycles since mode entered.
  int         m_mode, m_age, m_hold, m_next;
  bit         m_restart;
  logic [7:0] m_seg;

  always #5 clk = ~clk;

  led_display_sched #(.SCAN_DIV(SCAN_DIV), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .ms_valid(ms_valid), .alu_done(alu_done), .mode_btn(mode_btn),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
    .sel(sel), .an(an), .seg(seg)
  );

  function automatic int digit_of(int mode, int age);
    return (mode == 0) ? 0 : (age / SCAN_DIV) % 4;
  endfunction

  function automatic logic [1:0] sel_of(int mode);
    case (mode)
      0:       return 2'b11;
      1:       return 2'b00;
      2:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [3:0] an_of(int mode, int age);
    logic [3:0] one;
    int d;
    one = 4'b0001;
    d = digit_of(mode, age);
    if (mode == 0) return 4'b1111;
    return ~(one << d);
  endfunction

  function automatic logic [7:0] led_of(int d);
    case (d)
      0:       return LED0;
      1:       return LED1;
      2:       return LED2;
      default: return LED3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_age = 0; m_hold = 0; m_seg = 8'h00;
    end else begin
      m_seg = led_of(digit_of(m_mode, m_age));
      m_next = m_mode;
      m_restart = 1'b0;
      if (alu_done) m_next = 3;
      else if (ms_valid) begin m_next = 2; m_restart = 1'b1; end
      else if (din_valid) m_next = 1;
      else if (mode_btn) m_next = (m_mode == 0 || m_mode == 3) ? 1 : m_mode + 1;
      else if (m_mode == 2 && m_hold == HOLD_CYC - 1) m_next = 1;
      if (m_next == 2 && (m_mode != 2 || m_restart)) m_hold = 0;
      else if (m_next == 2) m_hold = m_hold + 1;
      if (m_next != m_mode) m_age = 0;
      else if (m_mode != 0) m_age = m_age + 1;
      m_mode = m_next;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      tests++;
      if (sel !== sel_of(m_mode)) begin
        failures++;
        $display("[TB] FAIL model_sel t=%0t got %b want %b", $time, sel, sel_of(m_mode));
      end
      tests++;
      if (an !== an_of(m_mode, m_age)) begin
        failures++;
        $display("[TB] FAIL model_an t=%0t got %b want %b", $time, an, an_of(m_mode, m_age));
      end
      tests++;
      if (seg !== m_seg) begin
        failures++;
        $display("[TB] FAIL model_seg t=%0t got %h want %h", $time, seg, m_seg);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got %h want %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs set right after a negedge, held across one posedge, then cleared.
  task automatic pulse(input logic a, input logic m, input logic d, input logic b);
    alu_done = a; ms_valid = m; din_valid = d; mode_btn = b;
    @(negedge clk);
    alu_done = 1'b0; ms_valid = 1'b0; din_valid = 1'b0; mode_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    din_valid = 1'b0; ms_valid = 1'b0; alu_done = 1'b0; mode_btn = 1'b0;
    LED0 = 8'h00; LED1 = 8'h00; LED2 = 8'h00; LED3 = 8'h00;
    step(1);
    check_en = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    check("idle_sel", {6'd0, sel}, 8'h03);
    check("idle_an", {4'd0, an}, 8'h0f);
    check("idle_seg", seg, 8'h00);

    LED0 = 8'h11; LED1 = 8'h22; LED2 = 8'h33; LED3 = 8'h44;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("btn_din_sel", {6'd0, sel}, 8'h00);
    check("din_an0", {4'd0, an}, 8'h0e);
    step(4);
    check("din_an1", {4'd0, an}, 8'h0d);
    check("din_seg_lag", seg, 8'h11);
    step(1);
    check("din_seg1", seg, 8'h22);
    step(3);
    check("din_an2", {4'd0, an}, 8'h0b);
    step(4);
    check("din_an3", {4'd0, an}, 8'h07);
    step(4);
    check("din_wrap", {4'd0, an}, 8'h0e);

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("ms_sel", {6'd0, sel}, 8'h01);
    check("ms_idx0", {4'd0, an}, 8'h0e);
    step(9);
    check("ms_hold_end", {6'd0, sel}, 8'h01);
    step(1);
    check("ms_timeout", {6'd0, sel}, 8'h00);

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    step(6);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    step(9);
    check("ms_ext_hold", {6'd0, sel}, 8'h01);
    step(1);
    check("ms_ext_timeout", {6'd0, sel}, 8'h00);

    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    check("prio_res", {6'd0, sel}, 8'h02);
    step(8);
    check("res_digit2", {4'd0, an}, 8'h0b);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("res_reentry_sel", {6'd0, sel}, 8'h02);
    check("res_reentry_an", {4'd0, an}, 8'h0b);

    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("din_again", {6'd0, sel}, 8'h00);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("btn1", {6'd0, sel}, 8'h01);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("btn2", {6'd0, sel}, 8'h02);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("btn3", {6'd0, sel}, 8'h00);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("btn4", {6'd0, sel}, 8'h01);
    step(9);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("timeout_evt_sel", {6'd0, sel}, 8'h00);
    step(3);
    check("timeout_evt_scan", {4'd0, an}, 8'h0e);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(8);
    check("pre_rst_digit2", {4'd0, an}, 8'h0b);
    rst = 1'b1;
    din_valid = 1'b1;
    step(1);
    rst = 1'b0;
    din_valid = 1'b0;
    check("rst_sel", {6'd0, sel}, 8'h03);
    check("rst_an", {4'd0, an}, 8'h0f);
    check("rst_seg", seg, 8'h00);
    step(2);
    check("post_rst_sel", {6'd0, sel}, 8'h03);
    check("post_rst_an", {4'd0, an}, 8'h0f);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
